// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path: serializer state encoding
// and the default word width, also used by the detector bench.
package seq_pkg;

   // state    | meaning
   // ST_IDLE  | nothing being shifted, o_seq parked at IDLE_BIT
   // ST_SHIFT | a word is on o_seq, one bit per cycle
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } seq_state_e;

   localparam int SEQ_DW_DEFAULT = 8;

endpackage

// File: rtl/seq_shift_reg.sv
// DW-bit loadable shift register that owns serial bit selection.
//   clk, rst_n : clock, async active-low reset
//   load       : capture din (has priority over shift)
//   shift      : advance one bit, back-filling IDLE_BIT
//   din        : parallel word
//   ser        : current serial bit (a flop output, so glitch-free)
// Back-filling with IDLE_BIT means that after DW shifts the register holds
// only IDLE_BIT, which lets ser drive the idle level without an output mux.
module seq_shift_reg #(
   parameter int   DW        = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          shift,
   input  logic [DW-1:0] din,
   output logic          ser
);

   logic [DW-1:0] sreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= {DW{IDLE_BIT}};
      end else if (load) begin
         sreg <= din;
      end else if (shift) begin
         if (MSB_FIRST) sreg <= {sreg[DW-2:0], IDLE_BIT};
         else           sreg <= {IDLE_BIT, sreg[DW-1:1]};
      end
   end

   assign ser = MSB_FIRST ? sreg[DW-1] : sreg[0];

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Accepts words on a
// valid/ready handshake and streams them one bit per clock with no gap
// between back-to-back words (one word shifting plus one pending).
//   i_clk, i_rstn : clock, async active-low reset
//   i_data/i_valid/o_ready : word handshake, transfer on i_valid && o_ready
//   o_seq, o_seq_valid     : serial bit and its qualifier (registered)
//   o_frame_done           : high on the cycle carrying a word's last bit
//   o_busy                 : shift or pending register occupied
//
// state    | meaning
// ST_IDLE  | no word shifting; o_seq = IDLE_BIT, o_seq_valid = 0
// ST_SHIFT | bit cnt of the current word is on o_seq
module seq_serializer
   import seq_pkg::*;
#(
   parameter int   DW        = SEQ_DW_DEFAULT,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   output logic          o_ready,
   output logic          o_seq,
   output logic          o_seq_valid,
   output logic          o_frame_done,
   output logic          o_busy
);

   localparam int            CW       = $clog2(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   seq_state_e    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [DW-1:0] pend_data;
   logic          pend_vld, pend_vld_nxt, pend_load;
   logic          sr_load, sr_shift;
   logic [DW-1:0] sr_din;
   logic          seq_valid_q, frame_done_q;
   logic          xfer;

   assign o_ready = !pend_vld;
   assign xfer    = i_valid && o_ready;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pend_vld_nxt = pend_vld;
      pend_load    = 1'b0;
      sr_load      = 1'b0;
      sr_shift     = 1'b0;
      sr_din       = i_data;
      unique case (state)
         ST_IDLE: begin
            if (xfer) begin
               sr_load   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (pend_vld) begin
                  sr_load      = 1'b1;
                  sr_din       = pend_data;
                  pend_vld_nxt = 1'b0;
               end else if (xfer) begin
                  // Empty pending slot: the new word goes straight in.
                  sr_load = 1'b1;
               end else begin
                  // Final shift leaves the register filled with IDLE_BIT.
                  sr_shift  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else begin
               sr_shift = 1'b1;
               cnt_nxt  = cnt + CW'(1);
               if (xfer) begin
                  pend_load    = 1'b1;
                  pend_vld_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         pend_vld     <= 1'b0;
         pend_data    <= '0;
         seq_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         pend_vld     <= pend_vld_nxt;
         if (pend_load) pend_data <= i_data;
         seq_valid_q  <= (state_nxt == ST_SHIFT);
         frame_done_q <= (state_nxt == ST_SHIFT) && (cnt_nxt == CNT_LAST);
      end
   end

   seq_shift_reg #(
      .DW        (DW),
      .MSB_FIRST (MSB_FIRST),
      .IDLE_BIT  (IDLE_BIT)
   ) u_shift (
      .clk   (i_clk),
      .rst_n (i_rstn),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (sr_din),
      .ser   (o_seq)
   );

   assign o_seq_valid  = seq_valid_q;
   assign o_frame_done = frame_done_q;
   assign o_busy       = (state == ST_SHIFT) || pend_vld;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance, a
// bit-queue reference model checked every cycle, and directed literal checks.
module tb_seq_serializer;

   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          valid [2];
   logic [DW-1:0] data  [2];
   logic          rdy [2], seq [2], sv [2], fd [2], busy [2];

   seq_serializer #(.DW(DW), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .i_clk(clk), .i_rstn(rst_n), .i_data(data[0]), .i_valid(valid[0]),
      .o_ready(rdy[0]), .o_seq(seq[0]), .o_seq_valid(sv[0]),
      .o_frame_done(fd[0]), .o_busy(busy[0]));

   seq_serializer #(.DW(DW), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .i_clk(clk), .i_rstn(rst_n), .i_data(data[1]), .i_valid(valid[1]),
      .o_ready(rdy[1]), .o_seq(seq[1]), .o_seq_valid(sv[1]),
      .o_frame_done(fd[1]), .o_busy(busy[1]));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: q[k] holds every bit still to appear, q[k][0] is the bit on the
   // wire this cycle. More than one word queued means the pending slot is full.
   bit   q [2][$];
   logic m_rdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q[0].delete();
         q[1].delete();
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_rdy = (q[k].size() <= DW);
            if (q[k].size() > 0) void'(q[k].pop_front());
            if (valid[k] && m_rdy)
               for (int i = 0; i < DW; i++)
                  q[k].push_back(k == 0 ? data[k][DW-1-i] : data[k][i]);
         end
      end
   end

   int sz;
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            sz = q[k].size();
            chk($sformatf("cyc%0d ready", k), rdy[k], (sz <= DW));
            chk($sformatf("cyc%0d seq_valid", k), sv[k], (sz > 0));
            chk($sformatf("cyc%0d seq", k), seq[k], (sz > 0) ? q[k][0] : 1'b0);
            chk($sformatf("cyc%0d frame_done", k), fd[k], (sz % DW == 1));
            chk($sformatf("cyc%0d busy", k), busy[k], (sz > 0));
         end
      end
   end

   task automatic capture(input int k, input int n, output logic [31:0] b,
                          output logic [31:0] v, output logic [31:0] f,
                          output logic [31:0] bz, output int nrdy);
      b = 0; v = 0; f = 0; bz = 0; nrdy = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         b  = {b[30:0], seq[k]};
         v  = {v[30:0], sv[k]};
         f  = {f[30:0], fd[k]};
         bz = {bz[30:0], busy[k]};
         if (!rdy[k]) nrdy++;
      end
   endtask

   task automatic send1(input int k, input logic [DW-1:0] w);
      valid[k] = 1'b1;
      data[k]  = w;
      @(posedge clk); #2;
      valid[k] = 1'b0;
   endtask

   task automatic send_stream(input int k, input logic [DW-1:0] w0,
                              input logic [DW-1:0] w1, input logic [DW-1:0] w2);
      logic [DW-1:0] ws [3];
      int   j, budget;
      logic r;
      ws = '{w0, w1, w2};
      j = 0; budget = 0;
      valid[k] = 1'b1;
      data[k]  = ws[0];
      while (j < 3 && budget < 100) begin
         @(negedge clk); r = rdy[k];
         @(posedge clk); #2; budget++;
         if (r) begin
            j++;
            if (j < 3) data[k] = ws[j];
            else       valid[k] = 1'b0;
         end
      end
      if (j < 3) begin
         valid[k] = 1'b0;
         chk("stream_accept_timeout", j, 3);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish by 100us");
      $fatal(1);
   end

   logic [31:0] b, v, f, bz;
   int          nr;
   logic        r6 [2];

   initial begin
      rst_n = 1'b0;
      valid = '{1'b0, 1'b0};
      data  = '{'0, '0};
      repeat (2) @(posedge clk); #2;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", rdy[k], 1);
         chk("rst_seq", seq[k], 0);
         chk("rst_seq_valid", sv[k], 0);
         chk("rst_frame_done", fd[k], 0);
         chk("rst_busy", busy[k], 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #2;

      // single word MSB first, samples cover cycles 0..9
      fork
         send1(0, 8'hB4);
         capture(0, 10, b, v, f, bz, nr);
      join
      chk("t1_bits", b, 32'h168);
      chk("t1_valid", v, 32'h1FE);
      chk("t1_frame", f, 32'h002);
      chk("t1_busy", bz, 32'h1FE);
      @(posedge clk); #2;

      // back-to-back words with i_valid held
      fork
         send_stream(0, 8'hFF, 8'h00, 8'hA5);
         capture(0, 25, b, v, f, bz, nr);
      join
      chk("t2_bits", b, 32'h0FF00A5);
      chk("t2_valid", v, 32'h0FFFFFF);
      chk("t2_frame", f, 32'h0010101);
      chk("t2_ready_low_cycles", nr, 14);
      @(posedge clk); #2;

      // LSB first
      fork
         send1(1, 8'h01);
         capture(1, 9, b, v, f, bz, nr);
      join
      chk("t3_bits_01", b, 32'h080);
      chk("t3_frame_01", f, 32'h001);
      @(posedge clk); #2;
      fork
         send1(1, 8'h80);
         capture(1, 9, b, v, f, bz, nr);
      join
      chk("t3_bits_80", b, 32'h001);
      chk("t3_valid_80", v, 32'h0FF);
      @(posedge clk); #2;

      // transfer exactly on the last-bit edge with pending empty
      fork
         begin
            send1(0, 8'hFF);
            repeat (7) @(posedge clk);
            #2;
            valid[0] = 1'b1;
            data[0]  = 8'h3C;
            @(posedge clk); #2;
            valid[0] = 1'b0;
         end
         capture(0, 17, b, v, f, bz, nr);
      join
      chk("t4_bits", b, 32'h0FF3C);
      chk("t4_valid", v, 32'h0FFFF);
      chk("t4_frame", f, 32'h00101);
      @(posedge clk); #2;

      // async reset mid-word
      send1(0, 8'hF0);
      repeat (3) @(posedge clk);
      #2;
      chk("t5_pre_valid", sv[0], 1);
      chk("t5_pre_seq", seq[0], 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", sv[0], 0);
      chk("t5_rst_seq", seq[0], 0);
      chk("t5_rst_busy", busy[0], 0);
      chk("t5_rst_frame", fd[0], 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      fork
         send1(0, 8'h81);
         capture(0, 10, b, v, f, bz, nr);
      join
      chk("t5_bits", b, 32'h102);
      chk("t5_valid", v, 32'h1FE);
      @(posedge clk); #2;

      // random traffic on both instances, checked by the model every cycle
      r6 = '{1'b1, 1'b1};
      for (int c = 0; c < 60; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!valid[k] || r6[k]) begin
               valid[k] = ($urandom_range(0, 3) != 0);
               data[k]  = DW'($urandom);
            end
         end
         @(negedge clk);
         r6[0] = rdy[0];
         r6[1] = rdy[1];
         @(posedge clk); #2;
      end
      valid = '{1'b0, 1'b0};
      repeat (30) @(posedge clk);
      #2;
      chk("t6_drain_busy_m", busy[0], 0);
      chk("t6_drain_busy_l", busy[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
